jtframe_char_layer: RTL
=======================

Name: jtframe_char_layer

Overview:
- Parametrised 8x8 character (text) tilemap layer with a CPU-shared 16-bit VRAM, a per-tile fetch FSM, a ROM handshake and a pixel shift register.
- Successor to the fixed-size game-specific char layers. Adds:
  - configurable map width, code width and palette width;
  - horizontal scroll;
  - screen flip;
  - a ROM-miss fallback.
- Sits between the video timing generator and the colour mixer; the ROM port connects to the SDRAM slot arbiter.

Parameters:
- COLW, 5, log2 of map columns (32). Map rows are fixed at 32; VRAM depth is 2^(COLW+5) words.
- CODEW, 11, tile code width; rom_addr width is CODEW+3.
- PALW, 2, palette bits per tile. CODEW+PALW must not exceed 16, checked at elaboration.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pxl_cen  in  1  pixel clock enable
- flip  in  1  screen flip, both axes
- h  in  9  horizontal dump counter; advances on pxl_cen and runs through blanking
- v  in  8  vertical dump counter
- scrx  in  9  horizontal scroll
- cpu_addr  in  COLW+6  byte address
- ram_cs  in  1  VRAM select
- cpu_wrn  in  1  write strobe, active low
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CPU read data; odd address returns the high byte
- rom_addr  out  CODEW+3  char ROM word address
- rom_cs  out  1  ROM request
- rom_data  in  32  8 pixels x 4bpp
- rom_ok  in  1  ROM data valid
- pxl  out  PALW+4  {pal, colour}; colour 0 is transparent

Behaviour:
- Reset: asserting rst_n low clears the FSM to IDLE and drives pxl, rom_addr and rom_cs to 0. The shift register and fetch buffer are cleared and the valid flag is dropped. VRAM contents are not cleared.
- VRAM is a dual-port 16-bit RAM.
  - CPU port: we = {a[0], ~a[0]} & (ram_cs & ~cpu_wrn); data is cpu_dout replicated on both bytes. Read latency is 1 clk.
  - Scan port is read-only. On a same-word CPU write, the scan port returns the old data.
- Word format: code = word[CODEW-1:0], pal = word[15 -: PALW].
- Positions:
  - hpos = h + scrx, mod 512.
  - vpos = v XOR {8{flip}}.
  - The next-tile column is ncol = (hpos[8:3]+1) mod 2^COLW, mirrored (bitwise NOT) when flip=1.
  - Scan address = {vpos[7:3], ncol}.
- Fetch FSM, running on clk (not gated by pxl_cen):
  - IDLE: leave on a pxl_cen with hpos[2:0]==0.
  - RAM: drive the scan address.
  - WAITRAM: latch code and pal.
  - ROM: rom_addr = {code, vpos[2:0]}, rom_cs = 1. Hold until rom_ok; then latch rom_data into the buffer, set valid and drop rom_cs.
  - DONE: wait for hpos[2:0]==7, then go to IDLE.
- Tile load:
  - On a pxl_cen with hpos[2:0]==7, the shift register and pal register load from the buffer and valid clears.
  - If valid==0 (ROM miss), load zeros; the tile renders transparent. The FSM abandons the pending request, drops rom_cs and goes to IDLE.
- Pixel order:
  - Pixel i (leftmost i=0) is rom_data[4i+3:4i].
  - flip=1 reverses the order: bits [31:28] are output first.
  - Shift 4 bits per pxl_cen.
- Latency: pxl is registered on pxl_cen. The pixel at hpos X is presented after the pxl_cen at which hpos==X. Tile N+1 is always fetched during tile N.
- Scroll change mid-line takes effect at the next tile boundary only. Fine phase follows hpos[2:0] on every pxl_cen.
- Budget: pxl_cen must be at most 1 per 4 clk. The whole fetch must fit in 8 pixel periods, or the ROM-miss rule applies.

Decomposition:
- Package jtframe_char_pkg holds:
  - the FSM state enum {IDLE, RAM, WAITRAM, ROM, DONE};
  - localparams for tile size 8, bits per pixel 4 and rows-width 5.
- One sub-module: jtframe_char_shift. It holds the 32-bit shift register and pal register, with load/flip/shift, and outputs pxl.
- The VRAM reuses jtframe_dual_ram16.

Test Plan:
- CPU write 0x34 to addr 0, 0x12 to addr 1; read both -> cpu_din 0x34 then 0x12, one clk after each read.
- Setup: tile (row 0, col 1) word 0xC005 (pal=3 with PALW=2, code 5), scrx=0, v=0, rom_ok asserted after 3 clk. Response:
  - rom_addr = 0x28 issued during h 0..7;
  - pxl sequence at h 8..15 equals rom_data nibbles [3:0] upward, pal bits 2'b11.
- flip=1, same data -> scan col 30 (NOT of ncol 1), rom_addr row bits 7, pixels emitted nibble [31:28] first.
- rom_ok held low -> at hpos[2:0]==7 pxl is 0 for 8 pixels, rom_cs drops, next tile fetches normally.
- scrx=3 -> first tile load occurs at h=4 (hpos=7); scrx=511 wraps hpos to 0 at h=1.
- Deassert rst_n mid-ROM-wait -> rom_cs and pxl read 0 immediately; after release, the FSM restarts at the next hpos[2:0]==0 and VRAM data is intact.

Source files
------------

// File: rtl/jtframe_char_pkg.sv
// Shared types and constants for the 8x8 character tilemap layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtframe_char_pkg;

  // Per-tile fetch sequencer states
  typedef enum logic [2:0] {
    IDLE,
    RAM,
    WAITRAM,
    ROM,
    DONE
  } char_st_t;

  localparam int TILE_SIZE = 8;   // pixels per tile side
  localparam int BPP       = 4;   // bits per pixel in the char ROM
  localparam int ROWW      = 5;   // log2 of map rows (32 rows)

endpackage

// File: rtl/jtframe_char_shift.sv
// Pixel serialiser: 32-bit tile row shift register plus palette register.
// Latency: pxl is registered on pxl_cen; a loaded tile shows on the next pxl_cen.
// Backpressure: none, advances on every pxl_cen.
//   clk, rst_n, pxl_cen : clock, async reset, pixel enable
//   load, data, pal     : take a new tile row and its palette on this pxl_cen
//   flip                : emit nibble [31:28] first instead of [3:0]
//   pxl                 : {pal, colour}
module jtframe_char_shift
  import jtframe_char_pkg::*;
#(
  parameter int PALW = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pxl_cen,
  input  logic                      load,
  input  logic                      flip,
  input  logic [TILE_SIZE*BPP-1:0]  data,
  input  logic [PALW-1:0]           pal,
  output logic [PALW+BPP-1:0]       pxl
);

  localparam int SW = TILE_SIZE * BPP;

  logic [SW-1:0]   sr;
  logic [PALW-1:0] pal_r;

  // The outgoing pixel is taken from the register before the load, so the
  // last pixel of the old tile is emitted on the load strobe itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      pal_r <= '0;
      pxl   <= '0;
    end else if (pxl_cen) begin
      pxl <= {pal_r, flip ? sr[SW-1 -: BPP] : sr[BPP-1:0]};
      if (load) begin
        sr    <= data;
        pal_r <= pal;
      end else begin
        sr <= flip ? (sr << BPP) : (sr >> BPP);
      end
    end
  end

endmodule

// File: rtl/jtframe_dual_ram16.sv
// Dual-port 16-bit RAM: port 0 read/write with byte enables, port 1 read-only.
// Latency: 1 clk read on both ports; a same-word write returns the old data.
// Backpressure: none, both ports accept an access every clock.
//   clk          : clock
//   addr0/data0/we0/q0 : read/write port, we0[1] high byte, we0[0] low byte
//   addr1/q1     : read-only port
module jtframe_dual_ram16 #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr0,
  input  logic [15:0]   data0,
  input  logic [1:0]    we0,
  output logic [15:0]   q0,
  input  logic [AW-1:0] addr1,
  output logic [15:0]   q1
);

  logic [15:0] mem [0:(2**AW)-1];

  // Reads sample the array before this edge's write lands, so a colliding
  // read on either port sees the previous contents.
  always_ff @(posedge clk) begin
    if (we0[0]) mem[addr0][7:0]  <= data0[7:0];
    if (we0[1]) mem[addr0][15:8] <= data0[15:8];
    q0 <= mem[addr0];
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtframe_char_layer.sv
// 8x8 character tilemap layer: CPU-shared VRAM, per-tile fetch, ROM request, pixel serialiser.
// Latency: pixel at hpos X is presented after the pxl_cen where hpos==X; tile N+1 fetched during tile N.
// Backpressure: ROM held via rom_cs until rom_ok; a fetch not done by the tile boundary renders transparent.
//   clk, rst_n, pxl_cen, flip, h, v, scrx : timing, reset and view controls
//   cpu_addr, ram_cs, cpu_wrn, cpu_dout, cpu_din : CPU byte port into the 16-bit VRAM
//   rom_addr, rom_cs, rom_data, rom_ok          : char ROM request/response
//   pxl                                         : {pal, colour}, colour 0 transparent
module jtframe_char_layer
  import jtframe_char_pkg::*;
#(
  parameter int COLW  = 5,
  parameter int CODEW = 11,
  parameter int PALW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic              flip,
  input  logic [8:0]        h,
  input  logic [7:0]        v,
  input  logic [8:0]        scrx,
  input  logic [COLW+5:0]   cpu_addr,
  input  logic              ram_cs,
  input  logic              cpu_wrn,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic [CODEW+2:0]  rom_addr,
  output logic              rom_cs,
  input  logic [31:0]       rom_data,
  input  logic              rom_ok,
  output logic [PALW+3:0]   pxl
);

  localparam int AW = COLW + ROWW;

  generate
    if (CODEW + PALW > 16) begin : g_bad_word
      $error("CODEW+PALW does not fit the 16-bit VRAM word");
    end
    if (COLW > 6) begin : g_bad_cols
      $error("COLW wider than the 6 tile-column bits of hpos");
    end
  endgenerate

  // ---------------- positions ----------------
  logic [8:0]      hpos;
  logic [7:0]      vpos;
  logic [5:0]      tile_col;
  logic [COLW-1:0] ncol;
  logic [AW-1:0]   scan_addr;

  assign hpos      = h + scrx;
  assign vpos      = v ^ {8{flip}};
  assign tile_col  = hpos[8:3] + 6'd1;          // always look one tile ahead
  assign ncol      = flip ? ~tile_col[COLW-1:0] : tile_col[COLW-1:0];
  assign scan_addr = {vpos[7 -: ROWW], ncol};

  // ---------------- VRAM ----------------
  logic [1:0]  cpu_we;
  logic [15:0] cpu_q;
  logic [15:0] scan_q;
  logic        cpu_a0_q;

  assign cpu_we = {cpu_addr[0], ~cpu_addr[0]} & {2{ram_cs & ~cpu_wrn}};

  jtframe_dual_ram16 #(.AW(AW)) u_vram (
    .clk   (clk),
    .addr0 (cpu_addr[AW:1]),
    .data0 ({2{cpu_dout}}),
    .we0   (cpu_we),
    .q0    (cpu_q),
    .addr1 (scan_addr),
    .q1    (scan_q)
  );

  // Byte select follows the address of the access that produced cpu_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_a0_q <= 1'b0;
    else        cpu_a0_q <= cpu_addr[0];
  end

  assign cpu_din = cpu_a0_q ? cpu_q[15:8] : cpu_q[7:0];

  // Column carry and the code/pal gap bits of the word are intentionally dropped
  logic unused_bits;
  assign unused_bits = ^{tile_col, scan_q};

  // ---------------- fetch FSM ----------------
  char_st_t        st, st_nxt;
  logic            tile_load;
  logic [31:0]     fetch_dat;
  logic            fetch_vld;
  logic [PALW-1:0] fetch_pal;

  assign tile_load = pxl_cen && (hpos[2:0] == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (tile_load) begin
      // Tile boundary always ends the current fetch, finished or not
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE:    if (pxl_cen && hpos[2:0] == 3'd0) st_nxt = RAM;
        RAM:     st_nxt = WAITRAM;
        WAITRAM: st_nxt = ROM;
        ROM:     if (rom_ok) st_nxt = DONE;
        DONE:    if (hpos[2:0] == 3'd7) st_nxt = IDLE;
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      rom_cs    <= 1'b0;
      fetch_pal <= '0;
      fetch_dat <= '0;
      fetch_vld <= 1'b0;
    end else if (tile_load) begin
      rom_cs    <= 1'b0;
      fetch_vld <= 1'b0;
    end else begin
      if (st == WAITRAM) begin
        rom_addr  <= {scan_q[CODEW-1:0], vpos[2:0]};
        fetch_pal <= scan_q[15 -: PALW];
        rom_cs    <= 1'b1;
      end
      if (st == ROM && rom_ok) begin
        fetch_dat <= rom_data;
        fetch_vld <= 1'b1;
        rom_cs    <= 1'b0;
      end
    end
  end

  // ---------------- pixel output ----------------
  jtframe_char_shift #(.PALW(PALW)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .pxl_cen (pxl_cen),
    .load    (tile_load),
    .flip    (flip),
    .data    (fetch_vld ? fetch_dat : 32'd0),
    .pal     (fetch_vld ? fetch_pal : {PALW{1'b0}}),
    .pxl     (pxl)
  );

endmodule
